clk_div_prog: RTL

- Runtime-programmable clock divider with enable. It generates a divided clock plus single-cycle phase ticks: rise, fall, mid-high, mid-low and period end.
- It drives SCL timing for the I2C master. The mid-phase ticks are the SDA change and sample points.
- The divisor can change on the fly. A new divisor takes effect only at a period boundary, so the output never glitches.

---
 rtl/clk_div_prog.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/clk_div_prog.sv
// ---------------------------------------------------------------------------
// clk_div_prog
//
// Runtime-programmable clock divider with enable. Produces a divided clock
// (idle high) and single-cycle phase ticks: rise, fall, mid-high, mid-low and
// period end. Intended as the SCL timing source of an I2C master; the mid-phase
// ticks serve as SDA change/sample points.
//
// All outputs are registered and reflect the counter value of the previous
// cycle. A new divisor is staged in a pending register and only becomes active
// on a period boundary, so clock_out never glitches.
//
// Parameters:
//   WIDTH       - width of divisor and counter
//   DEFAULT_DIV - divisor loaded at reset (values below 2 are treated as 2)
//
// Ports:
//   clock_in      in   system clock
//   reset_n       in   asynchronous active-low reset
//   enable        in   run divider; low holds counter at 0, clock_out high
//   div_in        in   new divisor value (0 and 1 clamp to 2)
//   div_load      in   single-cycle strobe capturing div_in
//   stretch_in    in   (CLK_DIV_PROG_STRETCH_EN only) hold the low phase at
//                      count D-1 while high
//   div_busy      out  captured divisor waiting for the period boundary
//   active_div    out  divisor currently in use
//   clock_out     out  divided clock
//   rise_tick     out  cycle in which clock_out goes 0->1
//   fall_tick     out  cycle in which clock_out goes 1->0
//   mid_high_tick out  quarter point of the high phase
//   mid_low_tick  out  quarter point of the low phase
//   period_tick   out  cycle after the counter passes D-1
//
// Optional feature macro: CLK_DIV_PROG_STRETCH_EN (adds stretch_in).
// ---------------------------------------------------------------------------
module clk_div_prog #(
  parameter int unsigned      WIDTH       = 16,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(4)
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
`ifdef CLK_DIV_PROG_STRETCH_EN
  input  logic             stretch_in,
`endif
  output logic             div_busy,
  output logic [WIDTH-1:0] active_div,
  output logic             clock_out,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic             mid_high_tick,
  output logic             mid_low_tick,
  output logic             period_tick
);

  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO       = WIDTH'(2);
  localparam logic [WIDTH-1:0] RESET_DIV = (DEFAULT_DIV < TWO) ? TWO : DEFAULT_DIV;

  // State registers
  logic [WIDTH-1:0] count_q,   count_d;
  logic [WIDTH-1:0] active_q,  active_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             busy_q,    busy_d;
  logic             clk_q,     clk_d;
  logic             rise_q,    rise_d;
  logic             fall_q,    fall_d;
  logic             mid_hi_q,  mid_hi_d;
  logic             mid_lo_q,  mid_lo_d;
  logic             period_q,  period_d;

  // Derived per-period decode points for the active divisor
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] last_w;
  logic [WIDTH-1:0] half_w;
  logic [WIDTH-1:0] quarter_w;
  logic [WIDTH-1:0] midlow_w;
  logic             at_last;
  logic             hold;
  logic             wrap;
  logic             level;
  logic             stretch;

`ifdef CLK_DIV_PROG_STRETCH_EN
  assign stretch = stretch_in;
`else
  assign stretch = 1'b0;
`endif

  always_comb begin
    load_val  = (div_in < TWO) ? TWO : div_in;
    last_w    = active_q - ONE;
    half_w    = active_q >> 1;
    quarter_w = active_q >> 2;
    // Low phase is D - D/2 cycles long; its quarter point sits halfway in.
    midlow_w  = half_w + ((active_q - half_w) >> 1);
    // >= keeps the counter bounded even if it were ever beyond D-1.
    at_last   = (count_q >= last_w);
    hold      = enable & at_last & stretch;
    wrap      = enable & at_last & ~hold;
    level     = (count_q < half_w);
  end

  always_comb begin
    count_d   = count_q;
    active_d  = active_q;
    pending_d = pending_q;
    busy_d    = busy_q;
    clk_d     = 1'b1;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    mid_hi_d  = 1'b0;
    mid_lo_d  = 1'b0;
    period_d  = 1'b0;

    if (!enable) begin
      // Idle: clock parked high; a low clock returns high with a rise tick.
      count_d = '0;
      clk_d   = 1'b1;
      rise_d  = ~clk_q;
      busy_d  = 1'b0;
      if (div_load) begin
        active_d = load_val;
      end else if (busy_q) begin
        active_d = pending_q;
      end
    end else begin
      if (wrap) begin
        count_d = '0;
      end else if (!hold) begin
        count_d = count_q + ONE;
      end

      clk_d    = level;
      // While held at D-1 the clock is already low, so rise/fall stay quiet.
      rise_d   = level & ~clk_q;
      fall_d   = ~level & clk_q;
      mid_hi_d = ~hold & (count_q == quarter_w);
      mid_lo_d = ~hold & (count_q == midlow_w);
      period_d = wrap;

      // A load coinciding with the wrap bypasses pending and wins over it.
      if (wrap) begin
        busy_d = 1'b0;
        if (div_load) begin
          active_d = load_val;
        end else if (busy_q) begin
          active_d = pending_q;
        end
      end else if (div_load) begin
        pending_d = load_val;
        busy_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      count_q   <= '0;
      active_q  <= RESET_DIV;
      pending_q <= '0;
      busy_q    <= 1'b0;
      clk_q     <= 1'b1;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      mid_hi_q  <= 1'b0;
      mid_lo_q  <= 1'b0;
      period_q  <= 1'b0;
    end else begin
      count_q   <= count_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
      clk_q     <= clk_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      mid_hi_q  <= mid_hi_d;
      mid_lo_q  <= mid_lo_d;
      period_q  <= period_d;
    end
  end

  assign div_busy      = busy_q;
  assign active_div    = active_q;
  assign clock_out     = clk_q;
  assign rise_tick     = rise_q;
  assign fall_tick     = fall_q;
  assign mid_high_tick = mid_hi_q;
  assign mid_low_tick  = mid_lo_q;
  assign period_tick   = period_q;

endmodule
